// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// Sends one latched byte as start bit, LSB-first data bits, optional parity
// bit and stop bit. Each bit lasts P CLK cycles, where P is the latched Prescale
// value with 0 treated as 1. TX_OUT and BUSY come straight from flops, so the
// line never glitches and no input reaches an output combinationally.
module uart_tx #(
    parameter int DATA_WIDTH    = 8,
    parameter int PRESCALE_BITS = 5,
    parameter int CNT_BITS      = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    P_DATA,
    input  logic                     DATA_VALID,
    input  logic [PRESCALE_BITS-1:0] Prescale,
    input  logic                     PAR_EN,
    input  logic                     PAR_TYP,
    output logic                     TX_OUT,
    output logic                     BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                   state_q, state_d;
    logic [PRESCALE_BITS-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_BITS-1:0]      bit_idx_q, bit_idx_d;
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;

    // Copies of the frame inputs, taken on the accepting edge. They are the
    // only source of frame data and configuration until the frame ends.
    logic [DATA_WIDTH-1:0]    data_q;
    logic [PRESCALE_BITS-1:0] last_q;      // P-1, with Prescale 0 folded to P = 1
    logic                     par_en_q;
    logic                     par_typ_q;

    logic                     load;
    logic                     bit_done;
    logic                     parity_bit;
    logic [PRESCALE_BITS-1:0] prescale_last;
    logic [DATA_WIDTH-1:0]    data_shift;

    assign prescale_last = (Prescale == '0) ? '0 : Prescale - 1'b1;
    assign bit_done      = (presc_cnt_q == last_q);
    assign parity_bit    = (^data_q) ^ par_typ_q;
    assign data_shift    = data_q >> bit_idx_d;

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

    // Next-state, counter and registered-output values for the frame FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d     = state_q;
        presc_cnt_d = presc_cnt_q;
        bit_idx_d   = bit_idx_q;
        load        = 1'b0;
        tx_d        = 1'b1;
        busy_d      = 1'b0;

        if (state_q != IDLE) begin
            presc_cnt_d = bit_done ? '0 : presc_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    load        = 1'b1;
                    state_d     = START;
                    presc_cnt_d = '0;
                    bit_idx_d   = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == CNT_BITS'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is a function of the state being entered, so the
        // registered TX_OUT changes on exactly the edge that starts each bit.
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_shift[0];
            PARITY:  tx_d = parity_bit;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register, bit/prescale counters and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            presc_cnt_q <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            presc_cnt_q <= presc_cnt_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    // Holding registers: capture the frame inputs on the accepting edge only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the holding registers are cleared too, so a frame aborted
            // by reset leaves no stale data or configuration behind.
            data_q    <= '0;
            last_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (load) begin
            data_q    <= P_DATA;
            last_q    <= prescale_last;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

endmodule
